// File: rtl/operand_loader.sv
// Operand loader: assembles NUM_WORDS little-endian input words into one
// X_W-bit operand, flags malformed operands, and hands complete operands to
// the downstream reduction stage through a one-deep output register.
module operand_loader #(
  parameter int WORD_W    = 32,
  parameter int X_W       = 300,
  parameter int NUM_WORDS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              x_valid,
  output logic [X_W-1:0]    x_data,
  input  logic              x_ready,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [15:0]       op_count
);

  localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  // Number of bits of the final word that land inside the operand.
  localparam int LAST_BITS = X_W - (NUM_WORDS - 1) * WORD_W;
  localparam logic [WORD_W-1:0] LAST_MASK = {WORD_W{1'b1}} >> (WORD_W - LAST_BITS);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(NUM_WORDS - 1);

  localparam logic [1:0] ERR_EARLY_LAST   = 2'b01;
  localparam logic [1:0] ERR_MISSING_LAST = 2'b10;
  localparam logic [1:0] ERR_OVERFLOW     = 2'b11;

  typedef enum logic [1:0] {COLLECT, HOLD, DISCARD} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [X_W-1:0]    asm_q, asm_d;
  logic              x_valid_q, x_valid_d;
  logic [X_W-1:0]    x_data_q, x_data_d;
  logic              err_valid_q, err_valid_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [15:0]       op_count_q, op_count_d;

  logic              accept;
  logic              pop;
  logic              out_free;
  logic              overflow;
  logic [X_W-1:0]    asm_wr;

  assign in_ready = (state_q != HOLD) && !reset;
  assign accept   = in_valid && in_ready;
  assign pop      = x_valid_q && x_ready;
  // The output register can take a new operand if it is empty or being drained now.
  assign out_free = !x_valid_q || pop;
  // Any set bit of the final word above the operand width is an overflow.
  assign overflow = |(in_data & ~LAST_MASK);

  // Assembly image with the incoming word merged into the slot chosen by the counter.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS - 1; gi++) begin : g_word
      assign asm_wr[gi*WORD_W +: WORD_W] =
        (cnt_q == CNT_W'(gi)) ? in_data : asm_q[gi*WORD_W +: WORD_W];
    end
  endgenerate
  assign asm_wr[(NUM_WORDS-1)*WORD_W +: LAST_BITS] =
    (cnt_q == LAST_IDX) ? in_data[LAST_BITS-1:0]
                        : asm_q[(NUM_WORDS-1)*WORD_W +: LAST_BITS];

  // Next-state logic: word collection, error detection, and output hand-off.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    x_valid_d   = x_valid_q && !pop;
    x_data_d    = x_data_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    op_count_d  = op_count_q + 16'(pop);

    case (state_q)
      COLLECT: begin
        if (accept) begin
          asm_d = asm_wr;
          if (cnt_q != LAST_IDX) begin
            if (in_last) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_EARLY_LAST;
              cnt_d       = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
            if (!in_last) begin
              // Missing terminator wins over overflow: the rest of the frame is junk.
              err_valid_d = 1'b1;
              err_code_d  = ERR_MISSING_LAST;
              state_d     = DISCARD;
            end else if (overflow) begin
              err_valid_d = 1'b1;
              err_code_d  = ERR_OVERFLOW;
            end else if (out_free) begin
              x_data_d  = asm_wr;
              x_valid_d = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (out_free) begin
          x_data_d  = asm_q;
          x_valid_d = 1'b1;
          state_d   = COLLECT;
        end
      end
      DISCARD: begin
        if (accept && in_last) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      asm_q       <= '0;
      x_valid_q   <= 1'b0;
      x_data_q    <= '0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
      op_count_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      x_valid_q   <= x_valid_d;
      x_data_q    <= x_data_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      op_count_q  <= op_count_d;
    end
  end

  assign x_valid   = x_valid_q;
  assign x_data    = x_data_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: a table of operand frames plus
// hand-written sequences for back-pressure, back-to-back hand-off and reset.
module tb_operand_loader;
  localparam int WORD_W    = 32;
  localparam int X_W       = 300;
  localparam int NUM_WORDS = 10;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;
  logic              x_valid;
  logic [X_W-1:0]    x_data;
  logic              x_ready;
  logic              err_valid;
  logic [1:0]        err_code;
  logic [15:0]       op_count;

  operand_loader #(.WORD_W(WORD_W), .X_W(X_W), .NUM_WORDS(NUM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .err_valid(err_valid), .err_code(err_code), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          nwords;   // words sent in this frame
    int          last_at;  // index carrying in_last (-1: none)
    logic [31:0] base;     // word k = base + k, except word 9
    logic [31:0] w9;       // value of word index 9
    int          err_at;   // word index whose edge raises err_valid (-1: none)
    logic [1:0]  code;     // expected err_code for that pulse
    bit          deliver;  // frame produces an operand
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [X_W-1:0] act, input logic [X_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [X_W-1:0] model(input logic [31:0] base, input logic [31:0] w9);
    logic [NUM_WORDS*WORD_W-1:0] full;
    for (int k = 0; k < NUM_WORDS; k++)
      full[k*WORD_W +: WORD_W] = (k == NUM_WORDS - 1) ? w9 : base + 32'(k);
    return full[X_W-1:0];
  endfunction

  // Sends a well-formed 10-word frame; x_ready is xr_body for words 0..8 and xr_last for word 9.
  task automatic send_op(input logic [31:0] base, input logic [31:0] w9,
                         input logic xr_body, input logic xr_last);
    for (int k = 0; k < NUM_WORDS; k++) begin
      in_valid = 1'b1;
      in_data  = (k == NUM_WORDS - 1) ? w9 : base + 32'(k);
      in_last  = (k == NUM_WORDS - 1);
      x_ready  = (k == NUM_WORDS - 1) ? xr_last : xr_body;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    logic [X_W-1:0] exp_x;
    logic [X_W-1:0] exp_a;
    logic [X_W-1:0] exp_b;
    logic [1:0]     held_code;
    logic [15:0]    exp_cnt;

    vecs[0] = '{10,  9, 32'h0000_0001, 32'h0000_000A, -1, 2'b00, 1'b1};
    vecs[1] = '{ 2,  1, 32'h0000_0040, 32'h0000_0000,  1, 2'b01, 1'b0};
    vecs[2] = '{10,  9, 32'h0000_0100, 32'h0000_0FFF, -1, 2'b00, 1'b1};
    vecs[3] = '{12, 11, 32'h0000_0300, 32'h0000_0001,  9, 2'b10, 1'b0};
    vecs[4] = '{10,  9, 32'h0000_2000, 32'h0000_0005, -1, 2'b00, 1'b1};
    vecs[5] = '{10,  9, 32'h0000_0500, 32'h0000_1FFF,  9, 2'b11, 1'b0};
    vecs[6] = '{10,  9, 32'hABCD_0000, 32'h0000_0123, -1, 2'b00, 1'b1};

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    x_ready  = 1'b0;
    held_code = 2'b00;
    exp_cnt   = 16'd0;

    #1;
    check("rst in_ready", in_ready, 0);
    check("rst x_valid", x_valid, 0);
    check("rst x_data", x_data, 0);
    check("rst err_valid", err_valid, 0);
    check("rst err_code", err_code, 0);
    check("rst op_count", op_count, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("post-rst in_ready", in_ready, 1);

    // Table-driven frames.
    for (int v = 0; v < 7; v++) begin
      exp_x = model(vecs[v].base, vecs[v].w9);
      for (int k = 0; k < vecs[v].nwords; k++) begin
        in_valid = 1'b1;
        in_data  = (k == NUM_WORDS - 1) ? vecs[v].w9 : vecs[v].base + 32'(k);
        in_last  = (k == vecs[v].last_at);
        x_ready  = 1'b1;
        tick();
        check($sformatf("v%0d w%0d err_valid", v, k), err_valid, (k == vecs[v].err_at));
        if (k == vecs[v].err_at) begin
          check($sformatf("v%0d w%0d err_code", v, k), err_code, vecs[v].code);
          held_code = vecs[v].code;
        end
        check($sformatf("v%0d w%0d x_valid", v, k), x_valid,
              (vecs[v].deliver && k == NUM_WORDS - 1));
        if (vecs[v].deliver && k == NUM_WORDS - 1)
          check($sformatf("v%0d x_data", v), x_data, exp_x);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      tick();
      if (vecs[v].deliver) exp_cnt = exp_cnt + 16'd1;
      check($sformatf("v%0d idle x_valid", v), x_valid, 0);
      check($sformatf("v%0d idle err_valid", v), err_valid, 0);
      check($sformatf("v%0d idle err_code", v), err_code, held_code);
      check($sformatf("v%0d idle op_count", v), op_count, exp_cnt);
      check($sformatf("v%0d idle in_ready", v), in_ready, 1);
    end

    // Back-pressure: second operand parks in HOLD, then both drain in order.
    exp_a = model(32'h0000_1000, 32'h0000_00AA);
    exp_b = model(32'h0000_2000, 32'h0000_00BB);
    send_op(32'h0000_1000, 32'h0000_00AA, 1'b0, 1'b0);
    check("hold A x_valid", x_valid, 1);
    check("hold A x_data", x_data, exp_a);
    check("hold A in_ready", in_ready, 1);
    send_op(32'h0000_2000, 32'h0000_00BB, 1'b0, 1'b0);
    check("hold in_ready", in_ready, 0);
    check("hold x_valid", x_valid, 1);
    check("hold x_data stable", x_data, exp_a);
    in_valid = 1'b1;
    in_data  = 32'h0000_DEAD;
    in_last  = 1'b1;
    tick();
    check("hold probe in_ready", in_ready, 0);
    check("hold probe x_data", x_data, exp_a);
    check("hold probe err_valid", err_valid, 0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    x_ready  = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check("hold pop1 x_valid", x_valid, 1);
    check("hold pop1 x_data", x_data, exp_b);
    check("hold pop1 op_count", op_count, exp_cnt);
    check("hold pop1 in_ready", in_ready, 1);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check("hold pop2 x_valid", x_valid, 0);
    check("hold pop2 op_count", op_count, exp_cnt);

    // Pop and load on the same edge straight from COLLECT.
    exp_a = model(32'h0000_3000, 32'h0000_0011);
    exp_b = model(32'h0000_4000, 32'h0000_0022);
    send_op(32'h0000_3000, 32'h0000_0011, 1'b0, 1'b0);
    check("b2b C x_data", x_data, exp_a);
    send_op(32'h0000_4000, 32'h0000_0022, 1'b0, 1'b1);
    exp_cnt = exp_cnt + 16'd1;
    check("b2b x_valid", x_valid, 1);
    check("b2b x_data", x_data, exp_b);
    check("b2b op_count", op_count, exp_cnt);
    tick();
    exp_cnt = exp_cnt + 16'd1;
    check("b2b drain x_valid", x_valid, 0);
    check("b2b drain op_count", op_count, exp_cnt);

    // Reset with a held operand and a half-built one in flight.
    send_op(32'h0000_5000, 32'h0000_0033, 1'b0, 1'b0);
    check("prerst x_valid", x_valid, 1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_6000 + 32'(k);
      in_last  = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midrst in_ready", in_ready, 0);
    check("midrst x_valid", x_valid, 0);
    check("midrst x_data", x_data, 0);
    check("midrst err_valid", err_valid, 0);
    check("midrst err_code", err_code, 0);
    check("midrst op_count", op_count, 0);
    tick();
    check("midrst held in_ready", in_ready, 0);
    reset = 1'b0;
    #1;
    exp_x = model(32'h0000_7000, 32'h0000_0044);
    send_op(32'h0000_7000, 32'h0000_0044, 1'b1, 1'b1);
    check("fresh x_valid", x_valid, 1);
    check("fresh x_data", x_data, exp_x);
    check("fresh err_valid", err_valid, 0);
    tick();
    check("fresh drain x_valid", x_valid, 0);
    check("fresh op_count", op_count, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
